// File: rtl/decode_queue.sv
// Instruction FIFO feeding a registered decode stage with a valid/ready output and a halt latch.
// Optional macro DECODE_ILLEGAL_TRAP_EN: opcodes 13/14 raise out_illegal and latch halt.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4,
    parameter int TAG_W = IDX_W + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3*IDX_W+3:0]       in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*TAG_W-1:0]       out_readregs,
    output logic [TAG_W-1:0]         out_writereg,
    output logic [7:0]               out_flags,
    output logic [3:0]               out_fuid,
    output logic                     out_halt,
    output logic                     out_illegal,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int INSTR_W = 3*IDX_W + 4;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               out_valid_reg, halted_reg;
    logic [2*TAG_W-1:0] readregs_reg;
    logic [TAG_W-1:0]   writereg_reg;
    logic [7:0]         flags_reg;
    logic [3:0]         fuid_reg;
    logic               push, load;

    logic [INSTR_W-1:0] head;
    logic [3:0]         op;
    logic [IDX_W-1:0]   fa, fb, fc;
    logic [TAG_W-1:0]   tag_a, tag_b, tag_c;
    logic               wa, wc, ra, rb;
    logic [7:0]         dec_flags;
    logic [3:0]         dec_fuid;
    logic [TAG_W-1:0]   dec_writereg;
    logic [2*TAG_W-1:0] dec_readregs;
    logic               dec_latch;

    assign in_ready = (count_reg < CNT_W'(DEPTH)) && !halted_reg && !flush;
    assign push     = in_valid && in_ready;
    // Once halted, the head stays parked in the FIFO until flush.
    assign load     = (count_reg != '0) && !halted_reg && (!out_valid_reg || out_ready) && !flush;

    assign head  = mem[rd_ptr_reg];
    assign op    = head[3:0];
    assign fa    = head[INSTR_W-1 -: IDX_W];
    assign fb    = head[INSTR_W-1-IDX_W -: IDX_W];
    assign fc    = head[4 +: IDX_W];
    assign tag_a = TAG_W'({fa, 1'b1});
    assign tag_b = TAG_W'({fb, 1'b1});
    assign tag_c = TAG_W'({fc, 1'b1});

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic dec_illegal;
    logic illegal_reg;
`endif

    always_comb begin
        wa = 1'b0; wc = 1'b0; ra = 1'b0; rb = 1'b0;
        dec_flags = 8'h00;
        dec_fuid  = 4'd0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec_illegal = 1'b0;
`endif
        case (op)
            4'd1:  begin wa = 1'b1; ra = 1'b1; rb = 1'b1; end
            4'd2:  begin wa = 1'b1; dec_flags = 8'h0E; end
            4'd3:  begin wa = 1'b1; dec_flags = 8'h06; end
            4'd4:  begin wc = 1'b1; ra = 1'b1; dec_fuid = 4'd1; end
            4'd5:  begin wc = 1'b1; ra = 1'b1; dec_fuid = 4'd5; end
            4'd6:  begin wc = 1'b1; ra = 1'b1; rb = 1'b1; dec_fuid = 4'd2; end
            4'd7:  begin wc = 1'b1; ra = 1'b1; dec_fuid = 4'd3; end
            4'd8:  begin wc = 1'b1; ra = 1'b1; dec_flags = 8'h02; dec_fuid = 4'd6; end
            4'd9:  begin ra = 1'b1; rb = 1'b1; dec_fuid = 4'd6; end
            4'd10: begin dec_flags = 8'h83; dec_fuid = 4'd1; end
            4'd11: begin wa = 1'b1; dec_flags = 8'h02; dec_fuid = 4'd1; end
            4'd12: begin ra = 1'b1; rb = 1'b1; dec_flags = 8'h01; dec_fuid = 4'd4; end
            4'd13, 4'd14: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec_illegal = 1'b1;
`else
                dec_flags = 8'h80;
`endif
                dec_fuid = 4'd1;
            end
            4'd15: begin dec_flags = 8'h10; dec_fuid = 4'd1; end
            default: ;
        endcase
    end

    assign dec_writereg = wa ? tag_a : (wc ? tag_c : '0);
    assign dec_readregs = {(rb ? tag_b : TAG_W'(0)), (ra ? tag_a : TAG_W'(0))};
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign dec_latch = dec_flags[4] || dec_illegal;
`else
    assign dec_latch = dec_flags[4];
`endif

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            halted_reg    <= 1'b0;
            readregs_reg  <= '0;
            writereg_reg  <= '0;
            flags_reg     <= '0;
            fuid_reg      <= '0;
        end else if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            halted_reg    <= 1'b0;
            readregs_reg  <= '0;
            writereg_reg  <= '0;
            flags_reg     <= '0;
            fuid_reg      <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (load)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !load)
                count_reg <= count_reg + CNT_W'(1);
            else if (!push && load)
                count_reg <= count_reg - CNT_W'(1);
            if (load) begin
                out_valid_reg <= 1'b1;
                readregs_reg  <= dec_readregs;
                writereg_reg  <= dec_writereg;
                flags_reg     <= dec_flags;
                fuid_reg      <= dec_fuid;
                if (dec_latch)
                    halted_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_reg <= 1'b0;
        else if (flush)
            illegal_reg <= 1'b0;
        else if (load)
            illegal_reg <= dec_illegal;
    end
    assign out_illegal = illegal_reg;
`else
    assign out_illegal = 1'b0;
`endif

    assign out_valid    = out_valid_reg;
    assign out_readregs = readregs_reg;
    assign out_writereg = writereg_reg;
    assign out_flags    = flags_reg;
    assign out_fuid     = fuid_reg;
    assign out_halt     = flags_reg[4];
    assign halted       = halted_reg;
    assign count        = count_reg;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: accepted words queue their expected micro-op,
// issued micro-ops are popped and compared; scenario tasks add direct checks.
module tb_decode_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_instr = '0;
    logic        in_ready, out_valid, out_halt, out_illegal, halted;
    logic [9:0]  out_readregs;
    logic [4:0]  out_writereg;
    logic [7:0]  out_flags;
    logic [3:0]  out_fuid;
    logic [2:0]  count;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [9:0] rr;
        logic [4:0] wr;
        logic [7:0] fl;
        logic [3:0] fu;
        logic       hl;
        logic       il;
    } uop_t;

    uop_t exp_q[$];

    decode_queue #(.DEPTH(4), .IDX_W(4), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_readregs(out_readregs), .out_writereg(out_writereg),
        .out_flags(out_flags), .out_fuid(out_fuid),
        .out_halt(out_halt), .out_illegal(out_illegal),
        .halted(halted), .count(count)
    );

    always #5 clk = ~clk;

    function automatic uop_t model(input logic [15:0] w);
        uop_t u;
        logic [3:0] op, a, b, c;
        logic wa, wc, ra, rb;
        {a, b, c, op} = w;
        wa = 1'b0; wc = 1'b0; ra = 1'b0; rb = 1'b0;
        u = '0;
        case (op)
            4'd0:  ;
            4'd1:  begin wa = 1'b1; ra = 1'b1; rb = 1'b1; end
            4'd2:  begin wa = 1'b1; u.fl = 8'h0E; end
            4'd3:  begin wa = 1'b1; u.fl = 8'h06; end
            4'd4:  begin wc = 1'b1; ra = 1'b1; u.fu = 4'd1; end
            4'd5:  begin wc = 1'b1; ra = 1'b1; u.fu = 4'd5; end
            4'd6:  begin wc = 1'b1; ra = 1'b1; rb = 1'b1; u.fu = 4'd2; end
            4'd7:  begin wc = 1'b1; ra = 1'b1; u.fu = 4'd3; end
            4'd8:  begin wc = 1'b1; ra = 1'b1; u.fl = 8'h02; u.fu = 4'd6; end
            4'd9:  begin ra = 1'b1; rb = 1'b1; u.fu = 4'd6; end
            4'd10: begin u.fl = 8'h83; u.fu = 4'd1; end
            4'd11: begin wa = 1'b1; u.fl = 8'h02; u.fu = 4'd1; end
            4'd12: begin ra = 1'b1; rb = 1'b1; u.fl = 8'h01; u.fu = 4'd4; end
            4'd13, 4'd14: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                u.il = 1'b1; u.fu = 4'd1;
`else
                u.fl = 8'h80; u.fu = 4'd1;
`endif
            end
            default: begin u.fl = 8'h10; u.fu = 4'd1; u.hl = 1'b1; end
        endcase
        u.wr = wa ? {a, 1'b1} : (wc ? {c, 1'b1} : 5'd0);
        u.rr = {(rb ? {b, 1'b1} : 5'd0), (ra ? {a, 1'b1} : 5'd0)};
        return u;
    endfunction

    // One clock: drive inputs, score any output handshake and accepted word, advance to edge+1.
    task automatic cycle(input logic v, input logic [15:0] w, input logic rdy, input logic fl);
        uop_t e, got;
        in_valid = v; in_instr = w; out_ready = rdy; flush = fl;
        #1;
        if (!fl && out_valid && rdy) begin
            got = {out_readregs, out_writereg, out_flags, out_fuid, out_halt, out_illegal};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL sb_spurious: got uop %h required no issue", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    mismatched++;
                    $display("FAIL sb_uop: got %h required %h", got, e);
                end else
                    $display("issue wr=%0h rr=%0h fl=%0h fu=%0h", got.wr, got.rr, got.fl, got.fu);
            end
        end
        if (fl) exp_q.delete();
        else if (v && in_ready) exp_q.push_back(model(w));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %0h required 0", out_valid); end
        compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL rst_count: got %0d required 0", count); end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL rst_halted: got %0h required 0", halted); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_in_ready: got %0h required 1", in_ready); end
        compared++; if ({out_readregs, out_writereg, out_flags, out_fuid, out_illegal} !== 28'd0) begin
            mismatched++; $display("FAIL rst_fields: got %h required 0", {out_readregs, out_writereg, out_flags, out_fuid, out_illegal});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_latency;
        cycle(1'b1, 16'h3211, 1'b1, 1'b0);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL lat_early: got %0h required 0", out_valid); end
        compared++; if (count !== 3'd1) begin mismatched++; $display("FAIL lat_count: got %0d required 1", count); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL lat_valid: got %0h required 1", out_valid); end
        compared++; if (out_writereg !== 5'd7) begin mismatched++; $display("FAIL alu_wr: got %0h required 7", out_writereg); end
        compared++; if (out_readregs !== 10'h0A7) begin mismatched++; $display("FAIL alu_rr: got %0h required a7", out_readregs); end
        compared++; if (out_fuid !== 4'd0 || out_flags !== 8'h00) begin mismatched++; $display("FAIL alu_fu_fl: got %0h/%0h required 0/0", out_fuid, out_flags); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure;
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (out_valid !== 1'b1 || out_writereg !== 5'd7 || out_readregs !== 10'h003 || out_fuid !== 4'd1) begin
                mismatched++;
                $display("FAIL hold_mov: got v=%0h wr=%0h rr=%0h fu=%0h required v=1 wr=7 rr=3 fu=1", out_valid, out_writereg, out_readregs, out_fuid);
            end
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
        compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL full_count: got %0d required 4", count); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL full_ready: got %0h required 0", in_ready); end
        cycle(1'b1, 16'h0005, 1'b0, 1'b0);
        compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL full_refuse: got %0d required 4", count); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
            compared++;
            if (count !== 3'((i < 4) ? 3 - i : 0)) begin
                mismatched++; $display("FAIL drain_count%0d: got %0d required %0d", i, count, (i < 4) ? 3 - i : 0);
            end
        end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL drain_idle: got %0h required 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] i4;
        for (int i = 0; i < 10; i++) begin
            i4 = 4'(i);
            cycle(1'b1, {i4, i4 + 4'd3, 4'd15 - i4, 4'(i % 13)}, 1'b1, 1'b0);
            compared++;
            if (count > 3'd1) begin mismatched++; $display("FAIL b2b_count%0d: got %0d required <=1", i, count); end
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        compared++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            mismatched++; $display("FAIL b2b_drain: got v=%0h left=%0d required v=0 left=0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_halt;
        cycle(1'b1, 16'h000F, 1'b1, 1'b0);
        cycle(1'b1, 16'h3211, 1'b1, 1'b0);
        compared++;
        if (out_valid !== 1'b1 || out_halt !== 1'b1 || halted !== 1'b1 || in_ready !== 1'b0 || count !== 3'd1) begin
            mismatched++;
            $display("FAIL halt_issue: got v=%0h oh=%0h h=%0h rdy=%0h cnt=%0d required 1 1 1 0 1", out_valid, out_halt, halted, in_ready, count);
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (out_valid !== 1'b0 || count !== 3'd1 || halted !== 1'b1) begin
                mismatched++; $display("FAIL halt_park%0d: got v=%0h cnt=%0d h=%0h required 0 1 1", i, out_valid, count, halted);
            end
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush;
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        cycle(1'b1, 16'h3211, 1'b0, 1'b0);
        cycle(1'b1, 16'h000F, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
        compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL fl_fill: got %0d required 4", count); end
        cycle(1'b1, 16'h0004, 1'b1, 1'b0);
        compared++;
        if (halted !== 1'b1 || count !== 3'd3 || out_halt !== 1'b1) begin
            mismatched++; $display("FAIL fl_prehalt: got h=%0h cnt=%0d oh=%0h required 1 3 1", halted, count, out_halt);
        end
        cycle(1'b1, 16'h0005, 1'b1, 1'b1);
        flush = 1'b0; in_valid = 1'b0; #1;
        compared++;
        if (count !== 3'd0 || out_valid !== 1'b0 || halted !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++; $display("FAIL fl_clear: got cnt=%0d v=%0h h=%0h rdy=%0h required 0 0 0 1", count, out_valid, halted, in_ready);
        end
        compared++; if (out_writereg !== 5'd0 || out_flags !== 8'h00) begin
            mismatched++; $display("FAIL fl_fields: got wr=%0h fl=%0h required 0 0", out_writereg, out_flags);
        end
        @(posedge clk); #1;
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        compared++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            mismatched++; $display("FAIL fl_dropped: got v=%0h cnt=%0d required 0 0", out_valid, count);
        end
    endtask

    task automatic test_illegal;
        cycle(1'b1, 16'h000D, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        compared++;
        if (out_illegal !== 1'b1 || out_flags !== 8'h00 || halted !== 1'b1 || out_fuid !== 4'd1 || out_halt !== 1'b0) begin
            mismatched++; $display("FAIL ill_trap: got il=%0h fl=%0h h=%0h fu=%0h oh=%0h required 1 0 1 1 0", out_illegal, out_flags, halted, out_fuid, out_halt);
        end
`else
        compared++;
        if (out_illegal !== 1'b0 || out_flags !== 8'h80 || halted !== 1'b0 || out_fuid !== 4'd1) begin
            mismatched++; $display("FAIL ill_plain: got il=%0h fl=%0h h=%0h fu=%0h required 0 80 0 1", out_illegal, out_flags, halted, out_fuid);
        end
`endif
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset;
        cycle(1'b1, 16'h3211, 1'b0, 1'b0);
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_writereg !== 5'd0) begin
            mismatched++; $display("FAIL arst: got cnt=%0d v=%0h wr=%0h required 0 0 0", count, out_valid, out_writereg);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        compared++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            mismatched++; $display("FAIL arst_after: got v=%0h cnt=%0d required 0 0", out_valid, count);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_alu_latency;
        test_backpressure;
        test_back_to_back;
        test_halt;
        test_flush;
        test_illegal;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-instruction combinational decoder.
- Buffers fetched instruction words in a DEPTH-entry FIFO, decodes the head entry, and presents one registered micro-op per cycle to rename/dispatch through a valid/ready handshake.
- Latches halt so that nothing issues after a Halt opcode until flush.
- Sits between fetch and rename.

Parameters:
- DEPTH, 4: instruction FIFO entries; power of two, ≥2.
- IDX_W, 4: register index field width. Instruction width is INSTR_W = 3*IDX_W+4.
- TAG_W, IDX_W+1: register tag width. A tag is {idx,1'b1}; 0 means "none".

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of queue, output stage and halt latch
- in_valid  in  1  fetch word valid
- in_ready  out  1  queue can accept
- in_instr  in  INSTR_W  raw instruction; opcode [3:0], fields a,b,c = [INSTR_W-1:4] MSB-first
- out_valid  out  1  micro-op valid
- out_ready  in  1  consumer accepts
- out_readregs  out  2*TAG_W  {rb_tag, ra_tag}; ra in low half
- out_writereg  out  TAG_W  destination tag
- out_flags  out  8  mode/immediate flags
- out_fuid  out  4  functional unit id
- out_halt  out  1  this micro-op is Halt
- out_illegal  out  1  see Optional Feature
- halted  out  1  halt latch
- count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Decode table. Opcode: ctl bits, flags, fuid. Ctl bits are wa = write a, wc = write c, ra = read a, rb = read b; wa has priority over wc.
  - 0 Noop: none, 0x00, 0
  - 1 ALU: wa ra rb, 0x00, 0
  - 2 AddImm: wa, 0x0E, 0
  - 3 XorImm: wa, 0x06, 0
  - 4 Mov: wc ra, 0x00, 1
  - 5 Shift: wc ra, 0x00, 5
  - 6 Mult: wc ra rb, 0x00, 2
  - 7 Hash: wc ra, 0x00, 3
  - 8 ReadRAM: wc ra, 0x02, 6
  - 9 WriteRAM: ra rb, 0x00, 6
  - 10 Jump: none, 0x83, 1
  - 11 WriteImm: wa, 0x02, 1
  - 12 Cjump: ra rb, 0x01, 4
  - 13/14: none, 0x80, 1
  - 15 Halt: none, 0x10, 1
- Tags: any tag whose ctl bit is clear is 0. out_halt = out_flags[4].
- Reset (rst_n low, async): FIFO empty, count 0, out_valid 0, all out_* fields 0, halted 0.
- in_ready = (count < DEPTH) && !halted && !flush.
- Push occurs when in_valid && in_ready. The write pointer wraps modulo DEPTH.
- Output register loads the decoded head when FIFO is non-empty, !halted, and (!out_valid || out_ready). The head is popped in the same cycle.
- If out_valid && !out_ready, outputs hold stable and nothing pops.
- Simultaneous push and pop: count unchanged. Push while full is impossible because in_ready is 0. A full FIFO with a concurrent pop still refuses the push (registered count).
- Latency: word accepted at edge N into an empty queue with an idle output is presented with out_valid=1 after edge N+1. Sustained throughput is 1 per cycle.
- Halt:
  - When a Halt micro-op loads into the output register, halted sets on the same edge.
  - Later queue entries are neither loaded nor popped, and in_ready drops.
  - The Halt micro-op itself completes its handshake normally; out_valid then falls to 0.
- Flush:
  - Clears FIFO, count, out_valid and halted on that edge; out_* fields go to 0.
  - in_valid and out_ready are ignored that cycle.
  - Flush dominates push, pop and load.
- Reset asserted mid-transfer discards all state immediately.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined: opcodes 13/14 decode with out_illegal=1, flags 0x00, fuid 1, no tags. They latch halted exactly like Halt, but out_halt stays 0.
- Undefined: opcodes 13/14 decode per table (0x80, fuid 1), out_illegal is constant 0, and halted is set only by Halt.

Test Plan:
- Reset, push 0x3211 (ALU a=3 b=2) -> after 2 edges: out_valid=1, writereg=7, readregs={5,7}, flags=0x00, fuid=0.
- Push 0x1234 (Mov a=1 c=3) with out_ready=0 for 3 cycles -> outputs hold writereg=7, readregs={0,3}, fuid=1. Pushes 0x0000..x3 more reach count=4 and in_ready=0. Raise out_ready -> 4 then 3 then... sustained one per cycle.
- Back-to-back pushes into an empty queue with out_ready=1 -> one micro-op per cycle, count stays ≤1, order preserved across pointer wrap (≥2*DEPTH words).
- Push Halt 0x000F followed by ALU -> Halt issues with out_halt=1, halted=1, in_ready=0. ALU never issues; count stays 1.
- Assert flush while halted, full FIFO, and in_valid=1 -> next cycle count=0, out_valid=0, halted=0, in_ready=1, and the pushed word is dropped.
- Push opcode 13 (0x000D) -> without macro: flags=0x80, fuid=1, halted=0. With DECODE_ILLEGAL_TRAP_EN: out_illegal=1, flags=0x00, halted=1.
